// File: rtl/case_9_mul_pkg.sv
// Shared definitions for the handshaked pipelined multiplier: operand mode
// encoding and result-range bounds used by the narrowing stage.
package case_9_mul_pkg;

  localparam logic SGN = 1'b1;
  localparam logic UNS = 1'b0;

  // Bounds are evaluated in a wide signed type so any product width fits.
  localparam int BOUND_W = 64;
  typedef logic signed [BOUND_W-1:0] bound_t;

  function automatic bound_t bound_min(input int w, input logic sgn);
    return (sgn == SGN) ? -(bound_t'(1) <<< (w - 1)) : '0;
  endfunction

  function automatic bound_t bound_max(input int w, input logic sgn);
    return (sgn == SGN) ? (bound_t'(1) <<< (w - 1)) - bound_t'(1)
                        : (bound_t'(1) <<< w) - bound_t'(1);
  endfunction

endpackage

// File: rtl/case_9_mul_narrow.sv
// Combinational narrowing of the full product to the output width, with
// overflow detection and optional clamping to the nearest range bound.
module case_9_mul_narrow
  import case_9_mul_pkg::*;
#(
  parameter int PW         = 17,
  parameter int DOUT_WIDTH = 10,
  parameter int SATURATE   = 0
) (
  input  logic signed [PW-1:0]         p,
  input  logic                         sgn,
  output logic        [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  bound_t p_ext;
  bound_t lo;
  bound_t hi;

  always_comb begin
    p_ext = bound_t'(p);
    lo    = bound_min(DOUT_WIDTH, sgn);
    hi    = bound_max(DOUT_WIDTH, sgn);
    ovf   = (p_ext < lo) || (p_ext > hi);
    dout  = p[DOUT_WIDTH-1:0];
    // An unsigned product is never negative, so only the upper clamp applies there.
    if (SATURATE != 0 && ovf) begin
      dout = (p_ext > hi) ? hi[DOUT_WIDTH-1:0] : lo[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/case_9_mul_pipe_hs.sv
// NUM_STAGE-deep multiplier with valid/ready handshake and a global stall:
// stage 1 registers the exact product, the last stage registers the narrowed result.
module case_9_mul_pipe_hs
  import case_9_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 9,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 10,
  parameter int NUM_STAGE  = 2,
  parameter int SATURATE   = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_a_sgn,
  input  logic                  in_b_sgn,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;

  logic                         ce;
  logic signed [DIN0_WIDTH:0]   a_ext;
  logic signed [DIN1_WIDTH:0]   b_ext;
  logic signed [PW-1:0]         p_in;
  logic                         res_sgn_in;

  logic [NUM_STAGE-1:0]         vld_q;
  logic [NUM_STAGE-1:0]         vld_d;

  logic signed [PW-1:0]         nar_p;
  logic                         nar_sgn;
  logic                         fin_load;
  logic [DOUT_WIDTH-1:0]        nar_dout;
  logic                         nar_ovf;

  logic [DOUT_WIDTH-1:0]        dout_q;
  logic [DOUT_WIDTH-1:0]        dout_d;
  logic                         ovf_q;
  logic                         ovf_d;

  // One extra bit per operand makes a single signed multiply exact for every mode mix.
  always_comb begin
    ce         = !vld_q[NUM_STAGE-1] || dout_ready;
    a_ext      = {(in_a_sgn == SGN) & din0[DIN0_WIDTH-1], din0};
    b_ext      = {(in_b_sgn == SGN) & din1[DIN1_WIDTH-1], din1};
    res_sgn_in = (in_a_sgn == SGN) || (in_b_sgn == SGN);
    p_in       = PW'(a_ext) * PW'(b_ext);
  end

  always_comb begin
    vld_d = vld_q;
    if (ce) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign nar_p    = p_in;
    assign nar_sgn  = res_sgn_in;
    assign fin_load = ce & in_valid;
  end else begin : g_pipe
    localparam int ND = NUM_STAGE - 1;

    logic signed [PW-1:0] prod_q [ND];
    logic signed [PW-1:0] prod_d [ND];
    logic                 sgn_q  [ND];
    logic                 sgn_d  [ND];

    // Data registers only load with a valid item, so idle stages keep their old contents.
    always_comb begin
      for (int s = 0; s < ND; s++) begin
        prod_d[s] = prod_q[s];
        sgn_d[s]  = sgn_q[s];
      end
      if (ce && in_valid) begin
        prod_d[0] = p_in;
        sgn_d[0]  = res_sgn_in;
      end
      for (int s = 1; s < ND; s++) begin
        if (ce && vld_q[s-1]) begin
          prod_d[s] = prod_q[s-1];
          sgn_d[s]  = sgn_q[s-1];
        end
      end
    end

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        for (int s = 0; s < ND; s++) begin
          prod_q[s] <= '0;
          sgn_q[s]  <= 1'b0;
        end
      end else begin
        for (int s = 0; s < ND; s++) begin
          prod_q[s] <= prod_d[s];
          sgn_q[s]  <= sgn_d[s];
        end
      end
    end

    assign nar_p    = prod_q[ND-1];
    assign nar_sgn  = sgn_q[ND-1];
    assign fin_load = ce & vld_q[NUM_STAGE-2];
  end

  case_9_mul_narrow #(
    .PW         (PW),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SATURATE   (SATURATE)
  ) u_narrow (
    .p    (nar_p),
    .sgn  (nar_sgn),
    .dout (nar_dout),
    .ovf  (nar_ovf)
  );

  always_comb begin
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (fin_load) begin
      dout_d = nar_dout;
      ovf_d  = nar_ovf;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready   = ce;
  assign dout_valid = vld_q[NUM_STAGE-1];
  assign dout       = dout_q;
  assign dout_ovf   = ovf_q;

endmodule

// File: tb/tb_case_9_mul_pipe_hs.sv
// Scoreboard bench: three configurations of the multiplier driven independently,
// expected results from a plain-arithmetic model, checked by one output monitor.
module tb_case_9_mul_pipe_hs;

  localparam int N_DUT     = 3;
  localparam int DRV_LIMIT = 200;

  function automatic int ns_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int dw_of(input int k);
    return (k == 1) ? 15 : 10;
  endfunction

  function automatic int sat_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  typedef struct packed {
    logic [14:0] d;
    logic        ovf;
    int          acc;
    logic        chk_lat;
  } exp_t;

  typedef struct packed {
    logic [8:0] a;
    logic [5:0] b;
    logic       as;
    logic       bs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_q = 1'b0;
  int   cyc = 0;

  logic        in_valid   [N_DUT];
  logic        in_a_sgn   [N_DUT];
  logic        in_b_sgn   [N_DUT];
  logic        dout_ready [N_DUT];
  logic [8:0]  din0       [N_DUT];
  logic [5:0]  din1       [N_DUT];
  logic        in_ready   [N_DUT];
  logic        dout_valid [N_DUT];
  logic        dout_ovf   [N_DUT];
  logic [9:0]  dout_0;
  logic [14:0] dout_1;
  logic [9:0]  dout_2;
  logic [14:0] dout_m     [N_DUT];

  exp_t exp_q [N_DUT][$];
  vec_t dir_v [13];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic final_chk = 1'b0;
  logic rand_done = 1'b0;

  logic        held_v [N_DUT];
  logic [14:0] held_d [N_DUT];
  logic        held_o [N_DUT];

  assign dout_m[0] = 15'(dout_0);
  assign dout_m[1] = dout_1;
  assign dout_m[2] = 15'(dout_2);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  case_9_mul_pipe_hs #(
    .DIN0_WIDTH(9), .DIN1_WIDTH(6), .DOUT_WIDTH(10), .NUM_STAGE(2), .SATURATE(0)
  ) u0 (
    .ap_clk(clk), .ap_rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a_sgn(in_a_sgn[0]), .in_b_sgn(in_b_sgn[0]),
    .din0(din0[0]), .din1(din1[0]),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]),
    .dout(dout_0), .dout_ovf(dout_ovf[0])
  );

  case_9_mul_pipe_hs #(
    .DIN0_WIDTH(9), .DIN1_WIDTH(6), .DOUT_WIDTH(15), .NUM_STAGE(1), .SATURATE(1)
  ) u1 (
    .ap_clk(clk), .ap_rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a_sgn(in_a_sgn[1]), .in_b_sgn(in_b_sgn[1]),
    .din0(din0[1]), .din1(din1[1]),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]),
    .dout(dout_1), .dout_ovf(dout_ovf[1])
  );

  case_9_mul_pipe_hs #(
    .DIN0_WIDTH(9), .DIN1_WIDTH(6), .DOUT_WIDTH(10), .NUM_STAGE(4), .SATURATE(1)
  ) u2 (
    .ap_clk(clk), .ap_rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a_sgn(in_a_sgn[2]), .in_b_sgn(in_b_sgn[2]),
    .din0(din0[2]), .din1(din1[2]),
    .dout_valid(dout_valid[2]), .dout_ready(dout_ready[2]),
    .dout(dout_2), .dout_ovf(dout_ovf[2])
  );

  // Reference: exact integer product, then range test and wrap/clamp by arithmetic.
  function automatic exp_t ref_model(input logic [8:0] a, input logic [5:0] b,
                                     input logic as, input logic bs,
                                     input int w, input int sat);
    longint av, bv, p, lo, hi, r;
    exp_t   e;
    av = as ? longint'($signed(a)) : longint'(a);
    bv = bs ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    if (as || bs) begin
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << w) - 1;
    end
    e.ovf = (p < lo) || (p > hi);
    r = p;
    if (sat != 0 && e.ovf) r = (p > hi) ? hi : lo;
    r = r & ((longint'(1) << w) - 1);
    e.d       = r[14:0];
    e.acc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // Presents one operand pair from posedge+1 until accepted; leaves in_valid low.
  task automatic drive(input int k, input logic [8:0] a, input logic [5:0] b,
                       input logic as, input logic bs, input logic lat);
    exp_t e;
    bit   done;
    done        = 1'b0;
    in_valid[k] = 1'b1;
    din0[k]     = a;
    din1[k]     = b;
    in_a_sgn[k] = as;
    in_b_sgn[k] = bs;
    for (int t = 0; t < DRV_LIMIT && !done; t++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        e         = ref_model(a, b, as, bs, dw_of(k), sat_of(k));
        e.acc     = cyc;
        e.chk_lat = lat;
        exp_q[k].push_back(e);
        done      = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    if (!done) begin
      $display("FAIL drive_timeout dut%0d: in_ready stayed %b for %0d cycles, required 1",
               k, in_ready[k], DRV_LIMIT);
      $fatal(1, "input handshake never completed");
    end
  endtask

  task automatic stream_dir(input int k);
    for (int i = 0; i < 13; i++)
      drive(k, dir_v[i].a, dir_v[i].b, dir_v[i].as, dir_v[i].bs, 1'b1);
  endtask

  task automatic stream_rnd(input int k, input int n, input int max_gap, input logic lat);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      drive(k, 9'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), lat);
    end
  endtask

  task automatic set_ready(input logic v);
    for (int k = 0; k < N_DUT; k++) dout_ready[k] = v;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (t < 600 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < N_DUT; k++) begin
      if (rst) exp_q[k].delete();
      if (rst_q) begin
        n_cmp++;
        if (dout_valid[k] !== 1'b0 || dout_m[k] !== 15'd0 || dout_ovf[k] !== 1'b0 ||
            in_ready[k] !== 1'b1) begin
          n_bad++;
          $display("FAIL reset_state dut%0d: valid=%b dout=%h ovf=%b in_ready=%b, required 0 0 0 1",
                   k, dout_valid[k], dout_m[k], dout_ovf[k], in_ready[k]);
        end
        held_v[k] = 1'b0;
      end else if (rst) begin
        held_v[k] = 1'b0;
      end else begin
        n_cmp++;
        if (in_ready[k] !== (!dout_valid[k] || dout_ready[k])) begin
          n_bad++;
          $display("FAIL in_ready_rule dut%0d: in_ready=%b, required %b (valid=%b ready=%b)",
                   k, in_ready[k], !dout_valid[k] || dout_ready[k], dout_valid[k], dout_ready[k]);
        end
        if (held_v[k]) begin
          n_cmp++;
          if (dout_valid[k] !== 1'b1 || dout_m[k] !== held_d[k] || dout_ovf[k] !== held_o[k]) begin
            n_bad++;
            $display("FAIL stall_hold dut%0d: valid=%b dout=%h ovf=%b, required 1 %h %b",
                     k, dout_valid[k], dout_m[k], dout_ovf[k], held_d[k], held_o[k]);
          end
        end
        if (dout_valid[k] && dout_ready[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output dut%0d: got dout=%h ovf=%b, required no output",
                     k, dout_m[k], dout_ovf[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (dout_m[k] !== e.d || dout_ovf[k] !== e.ovf) begin
              n_bad++;
              $display("FAIL result dut%0d: dout=%h ovf=%b, required dout=%h ovf=%b",
                       k, dout_m[k], dout_ovf[k], e.d, e.ovf);
            end
            if (e.chk_lat) begin
              n_cmp++;
              if (cyc - e.acc != ns_of(k)) begin
                n_bad++;
                $display("FAIL latency dut%0d: %0d cycles, required %0d",
                         k, cyc - e.acc, ns_of(k));
              end
            end
          end
        end
        held_v[k] = dout_valid[k] && !dout_ready[k];
        held_d[k] = dout_m[k];
        held_o[k] = dout_ovf[k];
      end
      if (final_chk) begin
        n_cmp++;
        if (exp_q[k].size() != 0) begin
          n_bad++;
          $display("FAIL lost_results dut%0d: %0d still expected, required 0",
                   k, exp_q[k].size());
        end
      end
    end
  end

  initial begin
    dir_v[0]  = '{a: 9'h100, b: 6'h20, as: 1'b1, bs: 1'b1};
    dir_v[1]  = '{a: 9'h007, b: 6'h3D, as: 1'b1, bs: 1'b1};
    dir_v[2]  = '{a: 9'h1FF, b: 6'h3F, as: 1'b0, bs: 1'b0};
    dir_v[3]  = '{a: 9'h1FF, b: 6'h3F, as: 1'b1, bs: 1'b0};
    dir_v[4]  = '{a: 9'h0FF, b: 6'h1F, as: 1'b1, bs: 1'b1};
    dir_v[5]  = '{a: 9'h100, b: 6'h1F, as: 1'b1, bs: 1'b1};
    dir_v[6]  = '{a: 9'h000, b: 6'h3F, as: 1'b1, bs: 1'b1};
    dir_v[7]  = '{a: 9'h1FF, b: 6'h20, as: 1'b0, bs: 1'b1};
    dir_v[8]  = '{a: 9'h1FF, b: 6'h01, as: 1'b0, bs: 1'b1};
    dir_v[9]  = '{a: 9'h100, b: 6'h02, as: 1'b0, bs: 1'b1};
    dir_v[10] = '{a: 9'h100, b: 6'h02, as: 1'b1, bs: 1'b1};
    dir_v[11] = '{a: 9'h155, b: 6'h03, as: 1'b0, bs: 1'b0};
    dir_v[12] = '{a: 9'h100, b: 6'h04, as: 1'b0, bs: 1'b0};

    rst = 1'b1;
    for (int k = 0; k < N_DUT; k++) begin
      in_valid[k]   = 1'b0;
      in_a_sgn[k]   = 1'b0;
      in_b_sgn[k]   = 1'b0;
      din0[k]       = '0;
      din1[k]       = '0;
      dout_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner products, back to back, consumer always ready.
    fork
      stream_dir(0);
      stream_dir(1);
      stream_dir(2);
    join
    drain();

    // Six-item stream with a four-cycle consumer stall in the middle.
    fork
      stream_rnd(0, 6, 0, 1'b0);
      stream_rnd(1, 6, 0, 1'b0);
      stream_rnd(2, 6, 0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        set_ready(1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_ready(1'b1);
      end
    join
    drain();

    // Two items in flight, then a one-cycle reset; nothing of theirs may emerge.
    fork
      stream_rnd(0, 2, 0, 1'b0);
      stream_rnd(1, 2, 0, 1'b0);
      stream_rnd(2, 2, 0, 1'b0);
    join
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    fork
      stream_rnd(0, 1, 0, 1'b1);
      stream_rnd(1, 1, 0, 1'b1);
      stream_rnd(2, 1, 0, 1'b1);
    join
    drain();

    // Random operands, modes, input gaps and consumer backpressure.
    rand_done = 1'b0;
    fork
      begin
        fork
          stream_rnd(0, 120, 2, 1'b0);
          stream_rnd(1, 120, 2, 1'b0);
          stream_rnd(2, 120, 2, 1'b0);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          for (int k = 0; k < N_DUT; k++) dout_ready[k] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk);
    #1;
    set_ready(1'b1);
    drain();

    // Ready-always stream: every result must come out exactly NUM_STAGE cycles later.
    fork
      stream_rnd(0, 20, 1, 1'b1);
      stream_rnd(1, 20, 1, 1'b1);
      stream_rnd(2, 20, 1, 1'b1);
    join
    drain();

    repeat (4) @(posedge clk);
    #1;
    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
